// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory / MMIO responder.
// Contents: MMIO word offsets from MMIO_BASE, STATUS register bit positions
// and the UART serializer state encoding.
package dsd_mmio_defs;

  // MMIO word offsets relative to MMIO_BASE
  localparam logic [15:0] OFF_TXDATA = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd1;
  localparam logic [15:0] OFF_CYCLE  = 16'd2;

  // STATUS register layout: {overflow, tx_busy, empty, full, count[3:0]}
  localparam int ST_OVERFLOW = 7;
  localparam int ST_BUSY     = 6;
  localparam int ST_EMPTY    = 5;
  localparam int ST_FULL     = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/dmem_mmio_responder_uart_tx.sv
// 8N1 UART transmit serializer, LSB first, fed from an external FIFO.
// Ports:
//   clk, resetn      - clock, synchronous active-low reset
//   fifo_empty       - FIFO has no entries
//   fifo_dout[7:0]   - byte at the FIFO head
//   pop              - consume the FIFO head this cycle
//   txd              - serial line (registered, idle high)
//   busy             - a frame is in progress (state != IDLE)
module uart_tx
  import dsd_mmio_defs::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       pop,
  output logic       txd,
  output logic       busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e    state_r;
  logic [BW-1:0]  baud_r;
  logic [2:0]     bit_idx_r;
  logic [7:0]     shift_r;
  logic           txd_r;
  logic           baud_end_s;

  assign baud_end_s = (baud_r == BAUD_LAST);
  // Pop from IDLE, or at the last STOP cycle so frames run back-to-back.
  assign pop  = !fifo_empty &&
                ((state_r == UART_IDLE) || ((state_r == UART_STOP) && baud_end_s));
  assign txd  = txd_r;
  assign busy = (state_r != UART_IDLE);

  // Serializer FSM: state, baud counter, bit index, shift register, line
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= UART_IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      txd_r     <= 1'b1;
    end else begin
      case (state_r)
        UART_IDLE: begin
          baud_r    <= '0;
          bit_idx_r <= 3'd0;
          if (pop) begin
            shift_r <= fifo_dout;
            txd_r   <= 1'b0;
            state_r <= UART_START;
          end
        end
        UART_START: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            txd_r   <= shift_r[0];
            state_r <= UART_DATA;
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        UART_DATA: begin
          if (baud_end_s) begin
            baud_r <= '0;
            if (bit_idx_r == 3'd7) begin
              bit_idx_r <= 3'd0;
              txd_r     <= 1'b1;
              state_r   <= UART_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              txd_r     <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        UART_STOP: begin
          if (baud_end_s) begin
            baud_r <= '0;
            if (pop) begin
              shift_r <= fifo_dout;
              txd_r   <= 1'b0;
              state_r <= UART_START;
            end else begin
              txd_r   <= 1'b1;
              state_r <= UART_IDLE;
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        default: begin
          baud_r  <= '0;
          txd_r   <= 1'b1;
          state_r <= UART_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory bus responder: word RAM at low addresses plus an MMIO window
// (UART TX FIFO, STATUS, free-running CYCLE counter) at MMIO_BASE.
// Ports:
//   clk, resetn          - clock, synchronous active-low reset
//   dmem_addr[15:0]      - word address from the core
//   dmem_data_out[31:0]  - write data from the core
//   dmem_wr              - write strobe
//   dmem_data_in[31:0]   - read data to the core (combinational, same cycle)
//   uart_txd             - serial output, idle high
module dmem_mmio_responder
  import dsd_mmio_defs::*;
#(
  parameter int          RAM_AW       = 10,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] MMIO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic        dmem_wr,
  output logic [31:0] dmem_data_in,
  output logic        uart_txd
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [16:0] RAM_WORDS = 17'd1 << RAM_AW;
  localparam logic [3:0]  DEPTH_C   = 4'(FIFO_DEPTH);

  logic [31:0]   ram_r  [0:(1<<RAM_AW)-1];
  logic [7:0]    fifo_r [0:FIFO_DEPTH-1];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [3:0]    count_r;
  logic          overflow_r;
  logic [31:0]   cycle_r;

  logic          ram_hit_s;
  logic          mmio_hit_s;
  logic [15:0]   mmio_off_s;
  logic          push_s;
  logic          push_ok_s;
  logic          pop_s;
  logic          ovf_clr_s;
  logic          cycle_wr_s;
  logic          full_s;
  logic          empty_s;
  logic          busy_s;
  logic [7:0]    status_s;

  assign ram_hit_s  = ({1'b0, dmem_addr} < RAM_WORDS);
  assign mmio_hit_s = (dmem_addr >= MMIO_BASE);
  assign mmio_off_s = dmem_addr - MMIO_BASE;
  assign full_s     = (count_r == DEPTH_C);
  assign empty_s    = (count_r == 4'd0);

  // Write-side decode of the MMIO window
  always_comb begin
    push_s     = 1'b0;
    ovf_clr_s  = 1'b0;
    cycle_wr_s = 1'b0;
    if (dmem_wr && mmio_hit_s) begin
      push_s     = (mmio_off_s == OFF_TXDATA);
      ovf_clr_s  = (mmio_off_s == OFF_STATUS) && dmem_data_out[7];
      cycle_wr_s = (mmio_off_s == OFF_CYCLE);
    end else begin
      push_s     = 1'b0;
    end
  end

  // A push into a full FIFO is still accepted when the serializer pops the same cycle.
  assign push_ok_s = push_s && (!full_s || pop_s);

  // STATUS register assembly
  always_comb begin
    status_s              = 8'd0;
    status_s[3:0]         = count_r;
    status_s[ST_FULL]     = full_s;
    status_s[ST_EMPTY]    = empty_s;
    status_s[ST_BUSY]     = busy_s;
    status_s[ST_OVERFLOW] = overflow_r;
  end

  // Read mux; the core consumes this in the same cycle
  always_comb begin
    dmem_data_in = 32'd0;
    if (ram_hit_s) begin
      dmem_data_in = ram_r[dmem_addr[RAM_AW-1:0]];
    end else if (mmio_hit_s) begin
      case (mmio_off_s)
        OFF_STATUS: dmem_data_in = {24'd0, status_s};
        OFF_CYCLE:  dmem_data_in = cycle_r;
        default:    dmem_data_in = 32'd0;
      endcase
    end else begin
      dmem_data_in = 32'd0;
    end
  end

  // Word RAM write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (resetn && dmem_wr && ram_hit_s) begin
      ram_r[dmem_addr[RAM_AW-1:0]] <= dmem_data_out;
    end
  end

  // FIFO storage write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (resetn && push_ok_s) begin
      fifo_r[wr_ptr_r] <= dmem_data_out[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= 4'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
      // A new overflow takes priority over a clear in the same cycle
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Free-running cycle counter; a bus write zeroes it and beats the increment
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_r <= 32'd0;
    end else if (cycle_wr_s) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (empty_s),
    .fifo_dout  (fifo_r[rd_ptr_r]),
    .pop        (pop_s),
    .txd        (uart_txd),
    .busy       (busy_s)
  );

endmodule
